gate_unit: RTL

- Parametrised successor to the single-bit two-input AND gate.
- Computes a selectable bitwise logic function of two WIDTH-bit operands.
- Results go through a registered 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between a stimulus source and a checker/consumer in gate-level learning and test designs. Also keeps a running count of results delivered.

---
 rtl/gate_unit_if.sv | 36 +++
 rtl/gate_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/gate_unit_if.sv
// Handshake bundle for gate_unit: operand/op input side and result output side.
// GATE_UNIT_REDUCE_EN adds the red_and/red_or/red_xor result-reduction signals.
interface gate_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       y_op;
  logic             out_valid;
  logic             out_ready;
`ifdef GATE_UNIT_REDUCE_EN
  logic             red_and;
  logic             red_or;
  logic             red_xor;
`endif

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, y, y_op, out_valid
`ifdef GATE_UNIT_REDUCE_EN
    , input red_and, red_or, red_xor
`endif
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, y, y_op, out_valid
`ifdef GATE_UNIT_REDUCE_EN
    , output red_and, red_or, red_xor
`endif
  );
endinterface

// File: rtl/gate_unit.sv
// Selectable bitwise logic function of a/b into a registered 2-entry FIFO with a pop counter.
// Latency 1 cycle into an empty buffer; in_ready/out_valid come from registered occupancy only. Optional: GATE_UNIT_REDUCE_EN.
module gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  gate_unit_if.slave       bus,
  output logic [CNT_W-1:0] out_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [2:0]       op;
`ifdef GATE_UNIT_REDUCE_EN
    logic             r_and;
    logic             r_or;
    logic             r_xor;
`endif
  } entry_t;

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           new_e;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res;
  logic             push;
  logic             pop;

  always_comb begin
    res = bus.a;
    case (bus.op)
      3'd0:    res = bus.a & bus.b;
      3'd1:    res = bus.a | bus.b;
      3'd2:    res = bus.a ^ bus.b;
      3'd3:    res = ~(bus.a & bus.b);
      3'd4:    res = ~(bus.a | bus.b);
      3'd5:    res = ~(bus.a ^ bus.b);
      3'd6:    res = bus.a & ~bus.b;
      default: res = bus.a;
    endcase
  end

  always_comb begin
    new_e     = '0;
    new_e.res = res;
    new_e.op  = bus.op;
`ifdef GATE_UNIT_REDUCE_EN
    new_e.r_and = &res;
    new_e.r_or  = |res;
    new_e.r_xor = ^res;
`endif
  end

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // head always holds the oldest entry; when the buffer drains it keeps the last value shown
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    if (pop) cnt_d = cnt_q + 1'b1;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = new_e;
        else                 tail_d = new_e;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      // both at once only happens with one entry held: the newcomer replaces the head
      2'b11:   head_d = new_e;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.y    = head_q.res;
  assign bus.y_op = head_q.op;
  assign out_cnt  = cnt_q;
`ifdef GATE_UNIT_REDUCE_EN
  assign bus.red_and = head_q.r_and;
  assign bus.red_or  = head_q.r_or;
  assign bus.red_xor = head_q.r_xor;
`endif

endmodule
